// File: rtl/dmem_access_unit_if.sv
// -----------------------------------------------------------------------------
// dmem_access_unit_if
// Data-memory bus between the MEM-stage access unit (master) and the memory
// (slave). There is one word-aligned transaction at a time. The master holds
// mem_req together with the address, data and lane mask until mem_ack returns.
//
//   mem_req    master->slave  bus request
//   mem_we     master->slave  write enable
//   mem_addr   master->slave  word-aligned byte address
//   mem_wdata  master->slave  lane-replicated store data
//   mem_wmask  master->slave  byte-lane enables (stores only)
//   mem_rdata  slave->master  read data, valid with mem_ack
//   mem_ack    slave->master  transaction completion
// -----------------------------------------------------------------------------
interface dmem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dmem_access_unit.sv
// -----------------------------------------------------------------------------
// dmem_access_unit
// Load/store responder between the MEM-stage pipeline and data memory.
// An aligned load or store presented in IDLE is latched. The unit then runs
// one bus transaction in REQ and spends one DONE cycle while the pipeline
// captures the result. It stalls the pipeline (busy) from the request cycle
// through the last REQ cycle. If the memory never acknowledges, the
// transaction is abandoned after TIMEOUT_CYCLES REQ cycles.
//
// Ports:
//   clk, reset        clock (rising edge) and asynchronous active-low reset
//   mem_read          pipeline presents a load
//   mem_write         pipeline presents a store
//   func3[2:0]        access size: 000 B, 001 H, 010 W, 100 BU, 101 HU (others W)
//   address[31:0]     byte address
//   write_data[31:0]  right-aligned store data
//   d_mem_result      formatted load data, held between loads
//   busy              combinational stall request
//   misalign_err      combinational: presented access is misaligned
//   bus_err           one-cycle pulse in DONE after a timeout
//   bus               memory bus (master side)
// -----------------------------------------------------------------------------
module dmem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic [2:0]                 func3,
  input  logic [31:0]                address,
  input  logic [31:0]                write_data,
  output logic [31:0]                d_mem_result,
  output logic                       busy,
  output logic                       misalign_err,
  output logic                       bus_err,
  dmem_access_unit_if.master         bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [15:0] TIMEOUT_W = TIMEOUT_CYCLES[15:0];

  logic [1:0]  state_r;
  logic [15:0] cnt_r;
  logic [2:0]  lat_func3_r;
  logic [1:0]  lat_addr_lo_r;
  logic        lat_write_r;
  logic [31:0] d_mem_result_r;
  logic        bus_err_r;
  logic        mem_req_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic [3:0]  mem_wmask_r;

  logic        access_s;
  logic        misaligned_s;
  logic        idle_s;
  logic        start_s;
  logic        timeout_s;

  // H/HU need an even address. W (and the unlisted codes) need a word-aligned address.
  function automatic logic misaligned_f(input logic [2:0] f3, input logic [1:0] a);
    logic m;
    case (f3[1:0])
      2'b00:   m = 1'b0;
      2'b01:   m = a[0];
      default: m = (a != 2'b00);
    endcase
    return m;
  endfunction

  // Replicate the store datum across every lane it could occupy.
  function automatic logic [31:0] store_data_f(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Byte-lane enables for a store of the given size at the given offset.
  function automatic logic [3:0] store_mask_f(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << a;
      2'b01:   m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Select the addressed lane of the read word and extend it to 32 bits.
  function automatic logic [31:0] load_format_f(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  // Request decode, the combinational stall/misalign flags and the timeout condition.
  always_comb begin
    access_s     = mem_read | mem_write;
    misaligned_s = misaligned_f(func3, address[1:0]);
    idle_s       = (state_r == ST_IDLE);
    start_s      = idle_s & access_s & ~misaligned_s;
    busy         = start_s | (state_r == ST_REQ);
    misalign_err = idle_s & access_s & misaligned_s;
    timeout_s    = (state_r == ST_REQ) & ~bus.mem_ack & ((cnt_r + 16'd1) == TIMEOUT_W);
  end

  // Transaction FSM with the latched request, the bus drivers and the result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      cnt_r          <= 16'd0;
      lat_func3_r    <= 3'd0;
      lat_addr_lo_r  <= 2'd0;
      lat_write_r    <= 1'b0;
      d_mem_result_r <= 32'd0;
      bus_err_r      <= 1'b0;
      mem_req_r      <= 1'b0;
      mem_we_r       <= 1'b0;
      mem_addr_r     <= 32'd0;
      mem_wdata_r    <= 32'd0;
      mem_wmask_r    <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bus_err_r <= 1'b0;
          if (start_s) begin
            state_r       <= ST_REQ;
            cnt_r         <= 16'd0;
            lat_func3_r   <= func3;
            lat_addr_lo_r <= address[1:0];
            lat_write_r   <= mem_write;
            mem_req_r     <= 1'b1;
            mem_we_r      <= mem_write;
            mem_addr_r    <= {address[31:2], 2'b00};
            mem_wdata_r   <= store_data_f(func3, write_data);
            mem_wmask_r   <= mem_write ? store_mask_f(func3, address[1:0]) : 4'b0000;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          // An ack on the same edge as the last allowed cycle still completes normally.
          if (bus.mem_ack) begin
            state_r     <= ST_DONE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_wmask_r <= 4'b0000;
            if (!lat_write_r) begin
              d_mem_result_r <= load_format_f(lat_func3_r, lat_addr_lo_r, bus.mem_rdata);
            end else begin
              d_mem_result_r <= d_mem_result_r;
            end
          end else if (timeout_s) begin
            state_r     <= ST_DONE;
            bus_err_r   <= 1'b1;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_wmask_r <= 4'b0000;
            if (!lat_write_r) begin
              d_mem_result_r <= 32'd0;
            end else begin
              d_mem_result_r <= d_mem_result_r;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_DONE: begin
          // The pipeline still presents the finished instruction here, so inputs are ignored.
          state_r   <= ST_IDLE;
          bus_err_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          bus_err_r   <= 1'b0;
          mem_req_r   <= 1'b0;
          mem_we_r    <= 1'b0;
          mem_wmask_r <= 4'b0000;
        end
      endcase
    end
  end

  assign d_mem_result  = d_mem_result_r;
  assign bus_err       = bus_err_r;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_wmask = mem_wmask_r;

endmodule

// File: tb/tb_dmem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_unit
// Self-checking bench for dmem_access_unit. It runs directed cases for the
// listed scenarios, then randomized loads, stores and idle cycles. Expected
// values come from a behavioural model written as access-size arithmetic.
// -----------------------------------------------------------------------------
module tb_dmem_access_unit;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  func3;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] d_mem_result;
  logic        busy;
  logic        misalign_err;
  logic        bus_err;

  int          checks;
  int          failures;
  logic [31:0] exp_result;

  dmem_access_unit_if bus_if ();

  dmem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .func3        (func3),
    .address      (address),
    .write_data   (write_data),
    .d_mem_result (d_mem_result),
    .busy         (busy),
    .misalign_err (misalign_err),
    .bus_err      (bus_err),
    .bus          (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes. Codes without a listed meaning are words.
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rd);
    int          sz;
    logic [31:0] v;
    sz = size_of(f3);
    if (sz == 4) return rd;
    v = rd >> (8 * (addr % 4));
    if (sz == 1) begin
      v = v & 32'h0000_00FF;
      if (f3 == 3'b000 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else begin
      v = v & 32'h0000_FFFF;
      if (f3 == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (size_of(f3))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] ref_wmask(input logic [2:0] f3, input logic [31:0] addr);
    int m;
    m = ((1 << size_of(f3)) - 1) << (addr % 4);
    return m;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One access. ack_at = REQ cycle that sees mem_ack (1-based). 0 means the memory never acknowledges.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rdata);
    int   n;
    logic mis;
    logic timed_out;
    next_cycle();
    bus_if.mem_ack = 1'b0;
    mem_read   = rd;
    mem_write  = wr;
    func3      = f3;
    address    = addr;
    write_data = wd;
    mis = (rd || wr) && ((addr % size_of(f3)) != 0);
    @(negedge clk);
    if (!rd && !wr) begin
      chk("nop_busy", busy, 0);
      chk("nop_mis", misalign_err, 0);
      next_cycle();
      chk("nop_req", bus_if.mem_req, 0);
      chk("nop_res", d_mem_result, exp_result);
      return;
    end
    if (mis) begin
      chk("mis_err", misalign_err, 1);
      chk("mis_busy", busy, 0);
      next_cycle();
      chk("mis_req", bus_if.mem_req, 0);
      chk("mis_res", d_mem_result, exp_result);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      return;
    end
    chk("start_busy", busy, 1);
    chk("start_mis", misalign_err, 0);
    chk("start_req", bus_if.mem_req, 0);
    timed_out = (ack_at == 0);
    n = timed_out ? TO : ack_at;
    next_cycle();
    for (int k = 1; k <= n; k++) begin
      // Bus outputs must not follow the pipeline inputs while in REQ.
      address    = $urandom;
      write_data = $urandom;
      func3      = 3'($urandom_range(0, 7));
      @(negedge clk);
      chk("req_hi", bus_if.mem_req, 1);
      chk("req_busy", busy, 1);
      chk("req_berr", bus_err, 0);
      chk("req_addr", bus_if.mem_addr, addr & 32'hFFFF_FFFC);
      chk("req_we", bus_if.mem_we, wr);
      chk("req_wmask", bus_if.mem_wmask, wr ? ref_wmask(f3, addr) : 32'd0);
      if (wr) chk("req_wdata", bus_if.mem_wdata, ref_wdata(f3, wd));
      if (k == n && !timed_out) begin
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = rdata;
      end
      next_cycle();
      bus_if.mem_ack   = 1'b0;
      bus_if.mem_rdata = $urandom;
    end
    // DONE: the same instruction is still presented, and a stray ack must be ignored.
    func3         = f3;
    address       = addr;
    write_data    = wd;
    bus_if.mem_ack = 1'b1;
    if (rd) exp_result = timed_out ? 32'd0 : ref_load(f3, addr, rdata);
    @(negedge clk);
    chk("done_req", bus_if.mem_req, 0);
    chk("done_busy", busy, 0);
    chk("done_berr", bus_err, timed_out);
    chk("done_res", d_mem_result, exp_result);
    next_cycle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    chk("after_berr", bus_err, 0);
    chk("after_busy", busy, 0);
    chk("after_req", bus_if.mem_req, 0);
    chk("after_res", d_mem_result, exp_result);
  endtask

  initial begin
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    int          sel;
    int          dly;
    checks     = 0;
    failures   = 0;
    exp_result = 32'd0;
    reset      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    func3      = 3'd0;
    address    = 32'd0;
    write_data = 32'd0;
    bus_if.mem_ack   = 1'b0;
    bus_if.mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_res", d_mem_result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mis", misalign_err, 0);
    chk("rst_berr", bus_err, 0);
    chk("rst_req", bus_if.mem_req, 0);
    chk("rst_we", bus_if.mem_we, 0);
    chk("rst_addr", bus_if.mem_addr, 0);
    chk("rst_wdata", bus_if.mem_wdata, 0);
    chk("rst_wmask", bus_if.mem_wmask, 0);
    reset = 1'b1;

    // Directed scenarios
    do_access(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 3, 32'h8011_2233);
    chk("lb_sext", d_mem_result, 32'hFFFF_FF80);
    do_access(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'd0, 1, 32'hBEEF_1234);
    chk("lhu_zext", d_mem_result, 32'h0000_BEEF);
    do_access(1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 2, 32'hDEAD_BEEF);
    chk("sb_res_held", d_mem_result, 32'h0000_BEEF);
    do_access(1'b0, 1'b1, 3'b010, 32'h0000_4002, 32'h1234_5678, 1, 32'd0);
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'd0, 0, 32'd0);
    chk("to_res", d_mem_result, 32'd0);
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_5004, 32'd0, TO, 32'hCAFE_F00D);
    do_access(1'b1, 1'b0, 3'b110, 32'h0000_5008, 32'd0, 2, 32'h1357_9BDF);

    // Reset while the request is outstanding
    next_cycle();
    mem_read = 1'b1;
    func3    = 3'b010;
    address  = 32'h0000_6008;
    next_cycle();
    next_cycle();
    #2;
    reset    = 1'b0;
    mem_read = 1'b0;
    #1;
    exp_result = 32'd0;
    chk("mrst_req", bus_if.mem_req, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_berr", bus_err, 0);
    chk("mrst_we", bus_if.mem_we, 0);
    chk("mrst_addr", bus_if.mem_addr, 0);
    chk("mrst_wmask", bus_if.mem_wmask, 0);
    chk("mrst_res", d_mem_result, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_600C, 32'd0, 2, 32'h0BAD_CAFE);
    chk("mrst_lw", d_mem_result, 32'h0BAD_CAFE);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      rd  = (sel >= 1 && sel <= 5);
      wr  = (sel >= 6);
      f3  = wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      a   = $urandom;
      dly = $urandom_range(0, 4);
      do_access(rd, wr, f3, a, $urandom, (dly == 4) ? 0 : dly + 1, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
